// File: rtl/counter161_pkg.sv
// counter161_pkg
//   Shared definitions for the 74LS161 front-panel control stage:
//   run/step FSM state encoding, key indices (lowest index wins) and the
//   priority pick used by the top-level arbiter.
package counter161_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int NUM_KEYS = 4;

  // Key indices double as priority order: index 0 is the most important.
  localparam int KEY_CLR  = 0;
  localparam int KEY_LOAD = 1;
  localparam int KEY_RUN  = 2;
  localparam int KEY_STEP = 3;

  // Keeps only the lowest-index set bit (x & -x), so at most one press
  // survives per cycle and every lower-priority press is dropped.
  function automatic logic [NUM_KEYS-1:0] pick_highest(input logic [NUM_KEYS-1:0] presses);
    return presses & (~presses + {{(NUM_KEYS-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   One push-button front end: 2-flop synchroniser, debounce counter and a
//   registered one-cycle pulse on each debounced rising edge.
// Ports:
//   clk      in  system clock, rising edge
//   srst     in  synchronous active-high reset
//   i_key    in  raw button level, asynchronous to clk, may bounce
//   o_press  out one-cycle pulse, registered on the edge the level rises
module key_debounce
  import counter161_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic i_key,
  output logic o_press
);

  // Counter only ever holds 0..DEB_CYCLES-1; reaching DEB_CYCLES flips instead.
  localparam int CW = $clog2(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        // Any agreement restarts the stability window, so bounces are filtered.
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_sync2;  // releases flip the level but never pulse
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/counter161_ctrl.sv
// counter161_ctrl
//   Front-panel control stage feeding the 74LS161 counter model. Debounces
//   four buttons, arbitrates presses (Clr > Load > Run > Step), runs the
//   IDLE/RUN/STEP machine and registers every counter control output.
// Ports:
//   CLK, Reset           clock and synchronous active-high reset
//   KeyClr/Load/Run/Step raw active-high buttons
//   SW[3:0]              preset switches, SW[3]->D ... SW[0]->A
//   CO                   counter carry out, fed back for stop-at-terminal-count
//   Clear, Load          active-low one-cycle pulses to the counter
//   ENP, ENT             count enables (always equal)
//   D, C, B, A           preset value captured on a Load press
//   Running              high while in RUN
module counter161_ctrl
  import counter161_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter bit STOP_AT_TC = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       KeyClr,
  input  logic       KeyLoad,
  input  logic       KeyRun,
  input  logic       KeyStep,
  input  logic [3:0] SW,
  input  logic       CO,
  output logic       Clear,
  output logic       Load,
  output logic       ENP,
  output logic       ENT,
  output logic       D,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       Running
);

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_win;

  assign w_raw[KEY_CLR]  = KeyClr;
  assign w_raw[KEY_LOAD] = KeyLoad;
  assign w_raw[KEY_RUN]  = KeyRun;
  assign w_raw[KEY_STEP] = KeyStep;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk    (CLK),
        .srst   (Reset),
        .i_key  (w_raw[gi]),
        .o_press(w_press[gi])
      );
    end
  endgenerate

  assign w_win = pick_highest(w_press);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_co;
  logic       r_clear_n;
  logic       r_load_n;
  logic       r_en;
  logic       r_running;
  logic [3:0] r_dcba;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_win[KEY_RUN]) begin
          w_state_next = RUN;
        end else if (w_win[KEY_STEP]) begin
          w_state_next = STEP;
        end
      end
      RUN: begin
        // CO is taken from its register, so enables drop one cycle after CO is seen.
        if (w_win[KEY_RUN] || (STOP_AT_TC && r_co)) begin
          w_state_next = IDLE;
        end
      end
      STEP:    w_state_next = IDLE;  // exactly one enabled clock per step
      default: w_state_next = IDLE;
    endcase
    if (w_win[KEY_CLR]) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_co      <= 1'b0;
      r_clear_n <= 1'b1;
      r_load_n  <= 1'b1;
      r_en      <= 1'b0;
      r_running <= 1'b0;
      r_dcba    <= 4'b0000;
    end else begin
      r_state   <= w_state_next;
      r_co      <= CO;
      r_clear_n <= ~w_win[KEY_CLR];
      r_load_n  <= ~w_win[KEY_LOAD];
      if (w_win[KEY_LOAD]) begin
        r_dcba <= SW;
      end
      // Enables are decoded from the next state so they change with it.
      r_en      <= (w_state_next != IDLE);
      r_running <= (w_state_next == RUN);
    end
  end

  assign Clear   = r_clear_n;
  assign Load    = r_load_n;
  assign ENP     = r_en;
  assign ENT     = r_en;
  assign D       = r_dcba[3];
  assign C       = r_dcba[2];
  assign B       = r_dcba[1];
  assign A       = r_dcba[0];
  assign Running = r_running;

endmodule

// File: tb/tb_counter161_ctrl.sv
module tb_counter161_ctrl;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       Reset, KeyClr, KeyLoad, KeyRun, KeyStep, CO;
  logic [3:0] SW;

  logic clear0, load0, enp0, ent0, d0, c0, b0, a0, run0;
  logic clear1, load1, enp1, ent1, d1, c1, b1, a1, run1;
  logic [8:0] out0, out1;

  assign out0 = {clear0, load0, enp0, ent0, d0, c0, b0, a0, run0};
  assign out1 = {clear1, load1, enp1, ent1, d1, c1, b1, a1, run1};

  always #5 CLK = ~CLK;

  counter161_ctrl #(.DEB_CYCLES(DEB), .STOP_AT_TC(1'b0)) u_dut0 (
    .CLK(CLK), .Reset(Reset), .KeyClr(KeyClr), .KeyLoad(KeyLoad), .KeyRun(KeyRun),
    .KeyStep(KeyStep), .SW(SW), .CO(CO), .Clear(clear0), .Load(load0), .ENP(enp0),
    .ENT(ent0), .D(d0), .C(c0), .B(b0), .A(a0), .Running(run0));

  counter161_ctrl #(.DEB_CYCLES(DEB), .STOP_AT_TC(1'b1)) u_dut1 (
    .CLK(CLK), .Reset(Reset), .KeyClr(KeyClr), .KeyLoad(KeyLoad), .KeyRun(KeyRun),
    .KeyStep(KeyStep), .SW(SW), .CO(CO), .Clear(clear1), .Load(load1), .ENP(enp1),
    .ENT(ent1), .D(d1), .C(c1), .B(b1), .A(a1), .Running(run1));

  int n_pass = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  // Debounce is expressed as a window rule over the raw-sample history:
  // a key's level flips at edge t when the samples taken at edges t-2 .. t-DEB-1
  // all disagree with the level and no flip/reset happened in the last DEB edges.
  int         t;
  logic       hist [4][64];
  int         lf   [4];
  logic       deb  [4];
  logic       prs  [4];
  int         st   [2];      // 0 idle, 1 run, 2 step; index = STOP_AT_TC
  logic       m_clear, m_load, co_r;
  logic [3:0] m_dcba;

  function automatic int fsm(input int cur, input bit run_p, input bit step_p,
                             input bit co, input bit stop);
    if (cur == 2) return 0;
    if (run_p) return (cur == 0) ? 1 : 0;
    if (step_p && cur == 0) return 2;
    if (cur == 1 && stop && co) return 0;
    return cur;
  endfunction

  function automatic logic [8:0] ev(input logic clr, input logic ld, input logic en,
                                    input logic [3:0] dcba, input logic run);
    return {clr, ld, en, en, dcba, run};
  endfunction

  function automatic logic [8:0] model_out(input int d);
    return ev(m_clear, m_load, st[d] != 0, m_dcba, st[d] == 1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, got, exp);
  endtask

  task automatic tick();
    logic [3:0] raw;
    logic [3:0] np;
    logic       ok;
    int         win;
    raw = {KeyStep, KeyRun, KeyLoad, KeyClr};
    np  = 4'b0000;
    if (Reset) begin
      m_clear = 1'b1; m_load = 1'b1; m_dcba = 4'b0000; co_r = 1'b0;
      st[0] = 0; st[1] = 0;
      for (int k = 0; k < 4; k++) begin
        deb[k] = 1'b0; lf[k] = t; hist[k][t & 63] = 1'b0;
      end
    end else begin
      win = 4;
      for (int k = 3; k >= 0; k--) if (prs[k]) win = k;
      m_clear = (win != 0);
      m_load  = (win != 1);
      if (win == 1) m_dcba = SW;
      for (int d = 0; d < 2; d++)
        st[d] = (win == 0) ? 0 : fsm(st[d], win == 2, win == 3, co_r, d == 1);
      co_r = CO;
      for (int k = 0; k < 4; k++) begin
        ok = ((t - lf[k]) >= DEB);
        for (int j = 2; j <= DEB + 1; j++)
          if (hist[k][(t - j) & 63] == deb[k]) ok = 1'b0;
        if (ok) begin
          deb[k] = ~deb[k]; lf[k] = t; np[k] = deb[k];
        end
        hist[k][t & 63] = raw[k];
      end
    end
    for (int k = 0; k < 4; k++) prs[k] = np[k];
    @(posedge CLK);
    t++;
    @(negedge CLK);
    check("model_dut0", out0, model_out(0));
    check("model_dut1", out1, model_out(1));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] keys;   // {Step, Run, Load, Clr}
    logic [3:0] sw;
    logic       co;
    int         cyc;
    logic [8:0] exp0;
    logic [8:0] exp1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] keys, input logic [3:0] sw,
                     input logic co, input int cyc, input logic [8:0] e0, input logic [8:0] e1);
    vec_t v;
    v.rst = rst; v.keys = keys; v.sw = sw; v.co = co; v.cyc = cyc; v.exp0 = e0; v.exp1 = e1;
    tbl.push_back(v);
  endtask

  logic [8:0] R, L, RN, ST, CL;
  int         en_cnt;
  int         len;
  logic [3:0] rk;

  initial begin
    t = 0;
    for (int k = 0; k < 4; k++) begin
      lf[k] = 0; deb[k] = 1'b0; prs[k] = 1'b0;
      for (int i = 0; i < 64; i++) hist[k][i] = 1'b0;
    end
    st[0] = 0; st[1] = 0;
    m_clear = 1'b1; m_load = 1'b1; m_dcba = 4'b0000; co_r = 1'b0;
    Reset = 1'b1; KeyClr = 1'b0; KeyLoad = 1'b0; KeyRun = 1'b0; KeyStep = 1'b0;
    CO = 1'b0; SW = 4'b0000;

    R  = ev(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    L  = ev(1'b1, 1'b1, 1'b0, 4'ha, 1'b0);
    RN = ev(1'b1, 1'b1, 1'b1, 4'ha, 1'b1);
    ST = ev(1'b1, 1'b1, 1'b1, 4'ha, 1'b0);
    CL = ev(1'b0, 1'b1, 1'b0, 4'ha, 1'b0);

    // reset with all keys held, then Clr wins after edge 6
    add(1, 4'hf, 4'h0, 0, 3, R, R);
    add(0, 4'hf, 4'h0, 0, 6, R, R);
    add(0, 4'hf, 4'h0, 0, 1, ev(1'b0, 1'b1, 1'b0, 4'h0, 1'b0), ev(1'b0, 1'b1, 1'b0, 4'h0, 1'b0));
    add(0, 4'hf, 4'h0, 0, 1, R, R);
    add(0, 4'hf, 4'h0, 0, 4, R, R);
    add(0, 4'h0, 4'h0, 0, 10, R, R);
    // load 1010, then hold through an SW change
    add(0, 4'b0010, 4'b1010, 0, 6, R, R);
    add(0, 4'b0010, 4'b1010, 0, 1, ev(1'b1, 1'b0, 1'b0, 4'ha, 1'b0), ev(1'b1, 1'b0, 1'b0, 4'ha, 1'b0));
    add(0, 4'b0010, 4'b1010, 0, 3, L, L);
    add(0, 4'b0000, 4'b0101, 0, 10, L, L);
    // bouncing Run key: 3 high / 3 low, then steady
    for (int i = 0; i < 5; i++) begin
      add(0, 4'b0100, 4'b0101, 0, 3, L, L);
      add(0, 4'b0000, 4'b0101, 0, 3, L, L);
    end
    add(0, 4'b0100, 4'b0101, 0, 6, L, L);
    add(0, 4'b0100, 4'b0101, 0, 1, RN, RN);
    add(0, 4'b0000, 4'b0101, 0, 8, RN, RN);
    // step while running is ignored
    add(0, 4'b1000, 4'b0101, 0, 10, RN, RN);
    add(0, 4'b0000, 4'b0101, 0, 8, RN, RN);
    // second Run press stops
    add(0, 4'b0100, 4'b0101, 0, 6, RN, RN);
    add(0, 4'b0100, 4'b0101, 0, 1, L, L);
    add(0, 4'b0000, 4'b0101, 0, 8, L, L);
    // step from idle: one enabled cycle
    add(0, 4'b1000, 4'b0101, 0, 6, L, L);
    add(0, 4'b1000, 4'b0101, 0, 1, ST, ST);
    add(0, 4'b1000, 4'b0101, 0, 1, L, L);
    add(0, 4'b0000, 4'b0101, 0, 8, L, L);
    // terminal count: only the STOP_AT_TC=1 instance leaves RUN
    add(0, 4'b0100, 4'b0101, 0, 6, L, L);
    add(0, 4'b0100, 4'b0101, 0, 1, RN, RN);
    add(0, 4'b0000, 4'b0101, 0, 2, RN, RN);
    add(0, 4'b0000, 4'b0101, 1, 1, RN, RN);
    add(0, 4'b0000, 4'b0101, 0, 1, RN, L);
    add(0, 4'b0000, 4'b0101, 0, 6, RN, L);
    // Clr forces IDLE out of RUN
    add(0, 4'b0001, 4'b0101, 0, 6, RN, L);
    add(0, 4'b0001, 4'b0101, 0, 1, CL, CL);
    add(0, 4'b0000, 4'b0101, 0, 8, L, L);
    // Clr and Run together: Run discarded
    add(0, 4'b0101, 4'b0101, 0, 6, L, L);
    add(0, 4'b0101, 4'b0101, 0, 1, CL, CL);
    add(0, 4'b0101, 4'b0101, 0, 1, L, L);
    add(0, 4'b0000, 4'b0101, 0, 8, L, L);

    foreach (tbl[i]) begin
      Reset = tbl[i].rst;
      {KeyStep, KeyRun, KeyLoad, KeyClr} = tbl[i].keys;
      SW = tbl[i].sw;
      CO = tbl[i].co;
      repeat (tbl[i].cyc) tick();
      check($sformatf("vec%0d_dut0", i), out0, tbl[i].exp0);
      check($sformatf("vec%0d_dut1", i), out1, tbl[i].exp1);
      $display("vec %0d keys=%b sw=%b co=%b cyc=%0d out0=%b out1=%b",
               i, tbl[i].keys, tbl[i].sw, tbl[i].co, tbl[i].cyc, out0, out1);
    end

    // back-to-back step presses: each gives exactly one enabled cycle
    for (int p = 0; p < 2; p++) begin
      en_cnt = 0;
      KeyStep = 1'b1;
      repeat (10) begin tick(); if (enp0 && ent0) en_cnt++; end
      KeyStep = 1'b0;
      repeat (8) begin tick(); if (enp0 && ent0) en_cnt++; end
      check($sformatf("step_pulse_%0d", p), en_cnt, 1);
      $display("step press %0d enabled cycles=%0d", p, en_cnt);
    end

    // key held across a reset is a fresh press after the full latency
    KeyRun = 1'b1;
    repeat (4) tick();
    Reset = 1'b1;
    repeat (2) tick();
    check("rst_mid_press", out0, R);
    Reset = 1'b0;
    repeat (6) tick();
    check("rst_fresh_wait", out0, R);
    tick();
    check("rst_fresh_run", out0, ev(1'b1, 1'b1, 1'b1, 4'h0, 1'b1));
    check("rst_fresh_run1", out1, ev(1'b1, 1'b1, 1'b1, 4'h0, 1'b1));
    $display("reset-through press out0=%b out1=%b", out0, out1);
    KeyRun = 1'b0;
    repeat (8) tick();

    // randomized segments against the model
    for (int seg = 0; seg < 160; seg++) begin
      len = $urandom_range(1, 12);
      rk  = 4'($urandom) & 4'($urandom);
      {KeyStep, KeyRun, KeyLoad, KeyClr} = rk;
      SW    = 4'($urandom);
      Reset = ($urandom_range(0, 39) == 0);
      repeat (len) begin
        CO = ($urandom_range(0, 5) == 0);
        tick();
      end
      Reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter161_ctrl.md
# counter161_ctrl

Front-panel control stage directly upstream of the 74LS161 counter model. It synchronises and debounces four raw push-buttons, and drives the counter's control and preset inputs: Clear, Load, ENP, ENT and D, C, B, A. A small run/step state machine drives the enables. The counter's CO is fed back so counting can optionally stop at terminal count.

## Interface
- DEB_CYCLES, default 16: consecutive stable cycles required before a debounced key level changes; legal range 2..65535.
- STOP_AT_TC, default 0: when 1, RUN state exits to IDLE on CO high.
- CLK  in  1  single system clock, rising edge; also the counter's CLK.
- Reset  in  1  synchronous, active-high reset.
- KeyClr, KeyLoad, KeyRun, KeyStep  in  1 each  raw active-high buttons, asynchronous to CLK, may bounce.
- SW  in  4  preset switches, SW[3]→D … SW[0]→A.
- CO  in  1  carry from counter.
- Clear  out  1  active-low clear to counter.
- Load  out  1  active-low load to counter.
- ENP, ENT  out  1 each  count enables, always driven equal.
- D, C, B, A  out  1 each  preset value.
- Running  out  1  high in RUN state.

## Operation
- Per key: 2-flop synchroniser → debounce counter → debounced level → 1-cycle press pulse on debounced rising edge. Releases produce no pulse.
- Debounce: the counter increments on each edge where the synchronised input ≠ the debounced level. It clears on any edge where they are equal. On the edge where it would reach DEB_CYCLES, the debounced level flips and the counter clears.
- Press priority per cycle: Clr > Load > Run > Step. Only the highest-priority press is acted on; lower-priority presses in the same cycle are discarded.
- Clr press: Clear low for exactly 1 cycle; FSM forced to IDLE.
- Load press: Load low for exactly 1 cycle. {D,C,B,A} captures SW in the same cycle and holds until the next Load press. FSM state is unchanged.
- FSM states: IDLE (ENP=ENT=0), RUN (ENP=ENT=1), STEP (ENP=ENT=1).
  - IDLE + Run → RUN
  - RUN + Run → IDLE
  - IDLE + Step → STEP
  - STEP → IDLE unconditionally next cycle, giving exactly one enabled clock.
  - Step in RUN or STEP is ignored.
  - STOP_AT_TC=1 and CO=1 in RUN → IDLE.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset values: Clear=1, Load=1, ENP=ENT=0, D=C=B=A=0, Running=0, FSM=IDLE. Synchronisers, debounce counters and debounced levels are all 0.
- Reset has priority over every key. A key held through reset deasserting is seen as a fresh press after the full latency.
- Latency example: key stable high and first sampled at edge 0. The synchronised value is high after edge 1, and the debounced level flips at edge DEB_CYCLES+1. The responding output (Clear/Load low, ENP/ENT change, Running) is valid after edge DEB_CYCLES+2.
- Bounce: any glitch shorter than DEB_CYCLES cycles is filtered, and each bounce restarts the count.
- Clear/Load low pulses are exactly 1 CLK cycle wide and never overlap.
- STEP enables are high for exactly 1 cycle; back-to-back step presses each yield one enabled cycle.
- CO is sampled registered: ENP/ENT drop 1 cycle after CO is seen high.

## Structure
- Shared package counter161_pkg: state enum (IDLE, RUN, STEP) and key-index constants (KEY_CLR=0, KEY_LOAD=1, KEY_RUN=2, KEY_STEP=3) defining priority order.
- Sub-module key_debounce (synchroniser + debounce counter + press pulse, parameter DEB_CYCLES), instantiated 4 times. The top level holds the arbiter, the FSM and the output registers.

## Test plan (DEB_CYCLES=4)
- Reset: hold Reset 3 cycles with all keys high → all outputs at reset values. Release → one Clear low pulse follows after edge 6, and no Load pulse occurs (Clr wins).
- Load: SW=4'b1010, KeyLoad high 10 cycles → Load low exactly 1 cycle after edge 6; {D,C,B,A}=1010 held after a later SW change.
- Bounce: KeyRun toggles with 3-cycle highs/lows for 30 cycles, then steady high → no change during bouncing; ENP=ENT=1 and Running=1 exactly 6 edges after steady.
- Run/stop: second Run press → ENP=ENT=0, Running=0. Step press in IDLE → ENP=ENT=1 for exactly 1 cycle. Step press in RUN → no effect.
- Terminal count: STOP_AT_TC=1, RUN, CO driven high 1 cycle → ENP=ENT=0 and Running=0 one cycle later. With STOP_AT_TC=0 → remains RUN.
- Simultaneous: KeyClr and KeyRun rise on the same edge in IDLE → Clear low 1 cycle, FSM stays IDLE, Run press discarded.
